tpu_rand_io_harness: RTL and testbench

//  Parametrised stimulus/observation harness around a multi-port TPU core.
//  - Drives NUM_CH wide write-data buses from per-channel xorshift32 generators.
//  - Captures any channel's wide read data and streams it out OUT_W bits per beat over a valid/ready port.
//  - Folds all read channels into a 32-bit MISR signature so wide results leave the chip on few pins.

---
 rtl/tpu_rand_io_harness.sv | 146 ++++++++++++++
 tb/tb_tpu_rand_io_harness.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_rand_io_harness.sv
// Stimulus/observation harness for a multi-port TPU core: per-channel
// xorshift32 write-data generators, serial capture of read data, 32-bit MISR.
module tpu_rand_io_harness #(
    parameter int          NUM_CH = 2,
    parameter int          DATA_W = 256,
    parameter int          OUT_W  = 8,
    parameter logic [31:0] SEED   = 32'h1,
    parameter int          CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     gen_en,
    output logic [NUM_CH*DATA_W-1:0] gen_data,
    input  logic [NUM_CH*DATA_W-1:0] rdata,
    input  logic                     cap_req,
    input  logic [CH_W-1:0]          cap_ch,
    output logic                     cap_ack,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_last,
    input  logic                     sig_en,
    input  logic                     sig_clr,
    output logic [31:0]              signature,
    output logic                     err_bad_ch
);

    localparam int WORDS = DATA_W / 32;
    localparam int BEATS = DATA_W / OUT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
    localparam logic [CH_W:0] NCH = (CH_W + 1)'(NUM_CH);
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] GOLD = 32'h9E3779B9;

    function automatic logic [31:0] seed_of(input int c);
        logic [31:0] s;
        s = SEED + 32'(c);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    function automatic logic [31:0] xs_next(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    // ---------------- generators ----------------
    logic [31:0] st [NUM_CH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < NUM_CH; c++) st[c] <= seed_of(c);
        end else if (gen_en) begin
            for (int c = 0; c < NUM_CH; c++) st[c] <= xs_next(st[c]);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        for (genvar j = 0; j < WORDS; j++) begin : g_word
            localparam logic [31:0] K = 32'(j) * GOLD;
            assign gen_data[(c*WORDS+j)*32 +: 32] = st[c] ^ K;
        end
    end

    // ---------------- capture FSM ----------------
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sel;
    logic              bad;

    // An out-of-range channel matches no slot, so it latches zeros.
    always_comb begin
        sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cap_ch == CH_W'(c)) sel = rdata[c*DATA_W +: DATA_W];
        end
        bad = {1'b0, cap_ch} >= NCH;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            cap_ack    <= 1'b0;
            out_valid  <= 1'b0;
            err_bad_ch <= 1'b0;
        end else begin
            cap_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cap_req) begin
                        shreg     <= sel;
                        cnt       <= '0;
                        cap_ack   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= SHIFT;
                        if (bad) err_bad_ch <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (out_ready) begin
                        if (cnt == LAST) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            cnt   <= cnt + CNT_W'(1);
                            shreg <= shreg >> OUT_W;
                        end
                    end
                end
            endcase
        end
    end

    assign out_data = shreg[OUT_W-1:0];
    assign out_last = (state == SHIFT) && (cnt == LAST);

    // ---------------- signature ----------------
    logic [31:0] fold;
    logic [31:0] sig;

    always_comb begin
        fold = '0;
        for (int w = 0; w < NUM_CH * WORDS; w++) fold = fold ^ rdata[w*32 +: 32];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sig <= '0;
        end else if (sig_clr) begin
            sig <= '0;
        end else if (sig_en) begin
            sig <= {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0) ^ fold;
        end
    end

    assign signature = sig;

endmodule

// File: tb/tb_tpu_rand_io_harness.sv
// Self-checking bench for tpu_rand_io_harness: table-driven signature vectors,
// random generator/signature checks against a reference model, capture sequences.
module tb_tpu_rand_io_harness;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 256;
    localparam int OUT_W  = 8;
    localparam int CH_W   = 2;
    localparam int WORDS  = DATA_W / 32;
    localparam int BEATS  = DATA_W / OUT_W;

    logic                     clk = 1'b0;
    logic                     resetn;
    logic                     gen_en;
    logic [NUM_CH*DATA_W-1:0] gen_data;
    logic [NUM_CH*DATA_W-1:0] rdata;
    logic                     cap_req;
    logic [CH_W-1:0]          cap_ch;
    logic                     cap_ack;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_data;
    logic                     out_last;
    logic                     sig_en;
    logic                     sig_clr;
    logic [31:0]              signature;
    logic                     err_bad_ch;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_st [NUM_CH];
    logic [31:0] m_sig;

    always #5 clk = ~clk;

    tpu_rand_io_harness #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .OUT_W(OUT_W),
        .SEED(32'h1), .CH_W(CH_W)
    ) dut (
        .clk(clk), .resetn(resetn), .gen_en(gen_en), .gen_data(gen_data),
        .rdata(rdata), .cap_req(cap_req), .cap_ch(cap_ch), .cap_ack(cap_ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .sig_en(sig_en), .sig_clr(sig_clr),
        .signature(signature), .err_bad_ch(err_bad_ch)
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic logic [31:0] xs(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    function automatic logic [31:0] gw(input int c, input int j);
        return m_st[c] ^ (32'(j) * 32'h9E3779B9);
    endfunction

    function automatic logic [31:0] sig_step(input logic [31:0] s,
                                             input logic [NUM_CH*DATA_W-1:0] d);
        logic [31:0] f;
        f = 32'h0;
        for (int w = 0; w < NUM_CH * WORDS; w++) f = f ^ d[w*32 +: 32];
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
    endfunction

    // One clock: the model follows the inputs presented at this edge.
    task automatic tick();
        if (gen_en) for (int c = 0; c < NUM_CH; c++) m_st[c] = xs(m_st[c]);
        if (sig_clr) m_sig = 32'h0;
        else if (sig_en) m_sig = sig_step(m_sig, rdata);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_st[0] = 32'h1;
        m_st[1] = 32'h2;
        m_sig   = 32'h0;
    endtask

    task automatic rand_rdata();
        for (int i = 0; i < NUM_CH * WORDS; i++) rdata[i*32 +: 32] = $urandom;
    endtask

    task automatic check_gen(input string tag);
        for (int c = 0; c < NUM_CH; c++)
            for (int j = 0; j < WORDS; j++)
                chk($sformatf("%s gen c%0d w%0d", tag, c, j),
                    gen_data[(c*WORDS+j)*32 +: 32], gw(c, j));
    endtask

    // mode 0: always ready, 1: ready toggles (first beat stalled), 2: random
    task automatic capture(input logic [CH_W-1:0] ch, input int mode,
                           input int hold, input logic [DATA_W-1:0] exp_v,
                           input string tag);
        int beats;
        int cyc;
        logic [OUT_W-1:0] pd;
        logic pl;
        logic pstall;
        cap_req = 1'b1;
        cap_ch  = ch;
        out_ready = 1'b0;
        tick();
        chk({tag, " cap_ack"}, cap_ack, 1);
        chk({tag, " valid"}, out_valid, 1);
        rand_rdata();
        beats = 0;
        cyc = 0;
        pstall = 1'b0;
        pd = '0;
        pl = 1'b0;
        while (beats < BEATS && cyc < 400) begin
            if (cyc > 0) chk({tag, " ack idle"}, cap_ack, 0);
            unique case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 2) == 1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (pstall) begin
                chk({tag, " stall data"}, out_data, pd);
                chk({tag, " stall last"}, out_last, pl);
            end
            chk({tag, " valid"}, out_valid, 1);
            if (!out_valid) break;
            if (out_ready) begin
                chk($sformatf("%s beat %0d", tag, beats), out_data,
                    exp_v[beats*OUT_W +: OUT_W]);
                chk($sformatf("%s last %0d", tag, beats), out_last,
                    beats == BEATS - 1);
                beats++;
            end
            pstall = !out_ready;
            pd = out_data;
            pl = out_last;
            cap_req = (cyc < hold);
            tick();
            cyc++;
        end
        cap_req = 1'b0;
        out_ready = 1'b0;
        chk({tag, " beat count"}, beats, BEATS);
        chk({tag, " valid after"}, out_valid, 0);
        tick();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        clr;
        logic        en;
        logic [31:0] exp;
    } sig_vec_t;

    sig_vec_t tbl [8];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [DATA_W-1:0] pat;
        logic [CH_W-1:0]   rc;

        tbl[0] = '{32'h0,          32'h0,          1'b1, 1'b0, 32'h00000000};
        tbl[1] = '{32'h1,          32'h0,          1'b0, 1'b1, 32'h00000001};
        tbl[2] = '{32'h1,          32'h0,          1'b0, 1'b1, 32'h00000003};
        tbl[3] = '{32'h1,          32'h0,          1'b1, 1'b1, 32'h00000000};
        tbl[4] = '{32'h5,          32'h0,          1'b0, 1'b0, 32'h00000000};
        tbl[5] = '{32'h0,          32'h80000000,   1'b0, 1'b1, 32'h80000000};
        tbl[6] = '{32'h0,          32'h0,          1'b0, 1'b1, 32'h04C11DB7};
        tbl[7] = '{32'h10,         32'h10,         1'b0, 1'b1, 32'h09823B6E};

        resetn = 1'b0;
        gen_en = 1'b0;
        rdata = '0;
        cap_req = 1'b0;
        cap_ch = '0;
        out_ready = 1'b0;
        sig_en = 1'b0;
        sig_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst valid", out_valid, 0);
        chk("rst ack", cap_ack, 0);
        chk("rst err", err_bad_ch, 0);
        chk("rst sig", signature, 0);
        resetn = 1'b1;
        tick();

        // generator seeds and first step
        chk("seed c0w0", gen_data[31:0], 32'h00000001);
        chk("seed c0w1", gen_data[63:32], 32'h9E3779B8);
        chk("seed c1w0", gen_data[DATA_W +: 32], 32'h00000002);
        gen_en = 1'b1;
        tick();
        gen_en = 1'b0;
        chk("step c0w0", gen_data[31:0], 32'h00042021);
        check_gen("step");
        for (int i = 0; i < 30; i++) begin
            gen_en = 1'($urandom_range(0, 1));
            tick();
            check_gen("rnd");
        end
        gen_en = 1'b0;
        tick();
        check_gen("hold");

        // signature vectors
        for (int i = 0; i < 8; i++) begin
            rdata = '0;
            rdata[31:0] = tbl[i].a;
            rdata[DATA_W + 7*32 +: 32] = tbl[i].b;
            sig_clr = tbl[i].clr;
            sig_en  = tbl[i].en;
            tick();
            chk($sformatf("sig vec %0d", i), signature, tbl[i].exp);
        end
        for (int i = 0; i < 12; i++) begin
            rand_rdata();
            sig_clr = ($urandom_range(0, 7) == 0);
            sig_en  = 1'($urandom_range(0, 1));
            tick();
            chk($sformatf("sig rnd %0d", i), signature, m_sig);
        end
        sig_clr = 1'b0;
        sig_en = 1'b0;

        // byte-ramp capture on channel 1, full rate then stalled
        rand_rdata();
        for (int i = 0; i < BEATS; i++) begin
            pat[i*8 +: 8] = 8'(i);
            rdata[DATA_W + i*8 +: 8] = 8'(i);
        end
        capture(2'd1, 0, 0, pat, "ramp");
        for (int i = 0; i < BEATS; i++) rdata[DATA_W + i*8 +: 8] = 8'(i);
        capture(2'd1, 1, 5, pat, "stall");
        chk("err before bad", err_bad_ch, 0);

        // out-of-range channel, then a good capture keeps the sticky flag
        rand_rdata();
        capture(2'd3, 0, 0, '0, "badch");
        chk("err after bad", err_bad_ch, 1);
        rand_rdata();
        pat = rdata[DATA_W-1:0];
        capture(2'd0, 2, 0, pat, "good");
        chk("err sticky", err_bad_ch, 1);

        for (int k = 0; k < 3; k++) begin
            rand_rdata();
            rc = CH_W'($urandom_range(0, 1));
            pat = rdata[rc*DATA_W +: DATA_W];
            capture(rc, 2, 0, pat, $sformatf("rnd%0d", k));
        end

        // reset in the middle of a stream
        rdata = '0;
        rdata[31:0] = 32'h5;
        sig_en = 1'b1;
        tick();
        sig_en = 1'b0;
        chk("sig pre rst", signature, m_sig);
        gen_en = 1'b1;
        tick();
        gen_en = 1'b0;
        for (int i = 0; i < BEATS; i++) rdata[DATA_W + i*8 +: 8] = 8'(i);
        cap_req = 1'b1;
        cap_ch = 2'd1;
        tick();
        cap_req = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        chk("mid beat10", out_data, 8'd10);
        chk("mid valid", out_valid, 1);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("abort valid", out_valid, 0);
        chk("abort last", out_last, 0);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();
        chk("post rst valid", out_valid, 0);
        chk("post rst sig", signature, 0);
        chk("post rst err", err_bad_ch, 0);
        chk("post rst c0w0", gen_data[31:0], 32'h00000001);
        chk("post rst c1w0", gen_data[DATA_W +: 32], 32'h00000002);
        check_gen("post rst");
        rand_rdata();
        pat = rdata[DATA_W +: DATA_W];
        capture(2'd1, 0, 0, pat, "resume");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
